frame_rd_ctrl: RTL and testbench
================================

Name: frame_rd_ctrl

Overview:
Read-side controller of the frame buffer. It tracks frames completed by the write controller and reads the selected frame slot from memory one line at a time, using AXI4 INCR bursts. It emits the frame as a 64-bit AXI4-Stream video stream: tuser on the first word of the frame, tlast on the last word of each line. It exchanges done strobes with the write controller so that slots are released and reused safely.

Parameters:
START_ADDR, 0, byte address of frame slot 0 (aligned to BURST_LEN*8 bytes)
FRAMES_AMOUNT, 3, number of frame slots in the ring
FRAME_RES_Y, 1080, lines per frame
FRAME_RES_X, 1920, pixels per line (4 pixels per 64-bit word)
ADDR_WIDTH, 32, AXI address width
BURST_LEN, 16, maximum beats per AR burst (1..256)

Ports:
clk_i  input  1  clock, all logic on its rising edge
rst_i  input  1  asynchronous active-high reset
wr_done_stb_i  input  1  one-cycle pulse; the writer completed one frame into the next slot
rd_done_stb_o  output  1  one-cycle pulse; the previously displayed slot is released
mem_rd  axi4_if.master  -  AXI4 memory port; only the AR and R channels are used
video_o  axi4_stream_if.master  64-bit data  video output stream

Behaviour:
- Derived values:
  - WPL = ceil(FRAME_RES_X/4) words per line
  - BPL = WPL*8 bytes per line
  - BPF = BPL*FRAME_RES_Y bytes per frame
  - slot k starts at START_ADDR + k*BPF
- Reset values:
  - all video_o outputs 0; arvalid 0; rready 0; rd_done_stb_o 0
  - avail_cnt 0; slot 0; first_frame 1; state IDLE
- Reset mid-operation: all state returns to IDLE immediately. Any partial burst or line is abandoned; no strobe is produced.
- Unused AXI channels are tied off: awvalid=0, wvalid=0, bready=1.
- avail_cnt (width clog2(FRAMES_AMOUNT)+1):
  - increments on wr_done_stb_i, saturating at FRAMES_AMOUNT
  - decrements when a frame is taken
  - a simultaneous increment and take leaves it unchanged
- State IDLE -> FRAME_SEL:
  - FRAME_SEL with avail_cnt>0:
    - if first_frame: use slot 0 and clear first_frame; no strobe
    - otherwise: advance slot (wrapping FRAMES_AMOUNT-1 -> 0) and pulse rd_done_stb_o in the same cycle
    - in both cases decrement avail_cnt, clear line_cnt, set sof, go to AR
  - FRAME_SEL with avail_cnt==0: stay in FRAME_SEL (see Optional Feature).
- State AR:
  - arvalid=1 with araddr = slot_addr + line_cnt*BPL + word_cnt*8
  - arlen = min(BURST_LEN, WPL-word_cnt) - 1
  - arsize=3, arburst=INCR, arid=0
  - all AR fields are held stable until arready
  - on the AR handshake -> R
- One burst is outstanding at a time.
- State R (zero-latency pass-through):
  - video_o.tvalid = rvalid; rready = video_o.tready; tdata = rdata
  - tuser = sof on the frame's first word; sof clears after that word's handshake
  - tlast=1 on word WPL-1 of the line
  - tkeep = tstrb = 8'hFF, except on the last word when FRAME_RES_X%4 != 0: low (FRAME_RES_X%4)*2 bits set
  - tid and tdest are 0
  - each handshake increments word_cnt
  - on the handshake with rlast:
    - if word_cnt has reached WPL: clear word_cnt, increment line_cnt, then go to FRAME_SEL if line_cnt==FRAME_RES_Y, else AR
    - otherwise go to AR
- rresp is ignored. An rlast that does not match the expected beat count has no defined recovery.
- Arithmetic: address sums are truncated to ADDR_WIDTH; line_cnt is clog2(FRAME_RES_Y)+1 bits.
- Backpressure: video_o.tready low stalls R without data loss, because rready follows tready.

Optional Feature:
FRAME_RD_CTRL_REPEAT_EN
- Defined: in FRAME_SEL with avail_cnt==0 and first_frame==0, the current slot is re-read (sof set, line_cnt cleared), with no strobe and no avail_cnt change. This keeps the output continuous when the writer is slower.
- Undefined: FRAME_SEL waits until avail_cnt>0. The output stalls between frames.
- Before the first frame, the block waits in both builds.

Test Plan:
Common settings: START_ADDR=0x1000, FRAME_RES_X=16, FRAME_RES_Y=4, FRAMES_AMOUNT=3, BURST_LEN=2, i.e. WPL=4, BPL=0x20, BPF=0x80; tready=1 unless stated.
- Reset, then one wr_done_stb_i pulse -> AR sequence 0x1000, 0x1010, 0x1020 ... 0x1070, all arlen=1. 16 output words; tuser on word 0 only; tlast on words 3, 7, 11, 15; no rd_done_stb_o.
- Three further wr_done pulses while frame 0 is read -> next frames start at 0x1080, 0x1100, then wrap to 0x1000. rd_done_stb_o pulses once at each frame start; avail_cnt saturates at 3.
- FRAME_RES_X=14 (WPL=4) -> last word of each line has tkeep=8'h0F and tlast=1; all other words have tkeep=8'hFF.
- Toggle tready randomly at 50% -> output data matches memory contents in order with no drops or duplicates; rready equals tready throughout.
- No wr_done after frame 0: REPEAT_EN build re-reads 0x1000 with no strobe; non-REPEAT build issues no AR until the next wr_done pulse, then reads from 0x1080.
- Assert rst_i during the R phase of line 2 -> outputs are 0 in the same cycle. After release and a new wr_done pulse, reading restarts at 0x1000 with tuser set.

Source files
------------

// File: rtl/frame_rd_ctrl.sv
// -----------------------------------------------------------------------------
// frame_rd_ctrl
//
// Read side of the frame buffer. Frames completed by the write controller are
// counted in avail_cnt. Each selected frame slot is read from memory line by
// line with AXI4 INCR bursts (one outstanding) and forwarded unchanged as a
// 64-bit AXI4-Stream video stream: tuser marks the first word of a frame and
// tlast the last word of every line. When a new slot is taken, the previously
// displayed slot is released to the writer with rd_done_stb_o.
//
// Optional build macro: FRAME_RD_CTRL_REPEAT_EN
//   defined   - with no new frame available, the current slot is read again so
//               the output stays continuous
//   undefined - the block waits in FRAME_SEL until a new frame is available
//
// Ports
//   clk_i            clock, all logic on its rising edge
//   rst_i            asynchronous active-high reset
//   wr_done_stb_i    pulse: the writer filled the next slot
//   rd_done_stb_o    pulse: the previously displayed slot is released
//   mem_aw/w/b_*     unused write channels, tied off
//   mem_ar*_o/_i     AXI4 read address channel
//   mem_r*_i/_o      AXI4 read data channel (rresp/rid not consumed)
//   video_*_o/_i     AXI4-Stream video output, 64-bit data
// -----------------------------------------------------------------------------
module frame_rd_ctrl #(
    parameter logic [63:0] START_ADDR    = 64'd0,
    parameter int unsigned FRAMES_AMOUNT = 3,
    parameter int unsigned FRAME_RES_Y   = 1080,
    parameter int unsigned FRAME_RES_X   = 1920,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned BURST_LEN     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_done_stb_i,
    output logic                  rd_done_stb_o,

    output logic                  mem_awvalid_o,
    output logic                  mem_wvalid_o,
    output logic                  mem_bready_o,

    output logic [3:0]            mem_arid_o,
    output logic [ADDR_WIDTH-1:0] mem_araddr_o,
    output logic [7:0]            mem_arlen_o,
    output logic [2:0]            mem_arsize_o,
    output logic [1:0]            mem_arburst_o,
    output logic                  mem_arvalid_o,
    input  logic                  mem_arready_i,

    input  logic [63:0]           mem_rdata_i,
    input  logic                  mem_rlast_i,
    input  logic                  mem_rvalid_i,
    output logic                  mem_rready_o,

    output logic [63:0]           video_tdata_o,
    output logic [7:0]            video_tkeep_o,
    output logic [7:0]            video_tstrb_o,
    output logic                  video_tuser_o,
    output logic                  video_tlast_o,
    output logic [3:0]            video_tid_o,
    output logic [3:0]            video_tdest_o,
    output logic                  video_tvalid_o,
    input  logic                  video_tready_i
);

    localparam int unsigned     WPL = (FRAME_RES_X + 3) / 4;
    localparam longint unsigned BPL = longint'(WPL) * 8;
    localparam longint unsigned BPF = BPL * longint'(FRAME_RES_Y);

    localparam int unsigned WC_W   = $clog2(WPL) + 1;
    localparam int unsigned LC_W   = $clog2(FRAME_RES_Y) + 1;
    localparam int unsigned AC_W   = $clog2(FRAMES_AMOUNT) + 1;
    localparam int unsigned SLOT_W = (FRAMES_AMOUNT > 1) ? $clog2(FRAMES_AMOUNT) : 1;

    localparam logic [ADDR_WIDTH-1:0] START_A    = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] BPF_A      = ADDR_WIDTH'(BPF);
    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(8);
    localparam logic [WC_W-1:0]       WPL_C      = WC_W'(WPL);
    localparam logic [WC_W-1:0]       LAST_WORD  = WC_W'(WPL - 1);
    localparam logic [LC_W-1:0]       LINES_C    = LC_W'(FRAME_RES_Y);
    localparam logic [AC_W-1:0]       AVAIL_MAX  = AC_W'(FRAMES_AMOUNT);
    localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(FRAMES_AMOUNT - 1);

    // Partial last word: two keep bits per valid pixel.
    localparam int unsigned XREM      = FRAME_RES_X % 4;
    localparam logic [7:0]  LAST_KEEP = (XREM == 0) ? 8'hFF : 8'((1 << (XREM * 2)) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FRAME_SEL,
        S_AR,
        S_R
    } state_t;

    state_t                  state_q, state_d;
    logic [AC_W-1:0]         avail_q, avail_d;
    logic                    first_q, first_d;
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WC_W-1:0]         word_q, word_d;
    logic [LC_W-1:0]         line_q, line_d;
    logic                    sof_q, sof_d;

    logic                    in_r;
    logic                    r_hs;
    logic                    take;
    logic                    strobe;
    logic [31:0]             remain;
    logic [31:0]             burst;

    always_comb begin
        state_d = state_q;
        avail_d = avail_q;
        first_d = first_q;
        slot_d  = slot_q;
        base_d  = base_q;
        addr_d  = addr_q;
        word_d  = word_q;
        line_d  = line_q;
        sof_d   = sof_q;
        take    = 1'b0;
        strobe  = 1'b0;
        in_r    = (state_q == S_R);
        r_hs    = in_r && mem_rvalid_i && video_tready_i;

        case (state_q)
            S_IDLE: begin
                state_d = S_FRAME_SEL;
            end
            S_FRAME_SEL: begin
                if (avail_q != '0) begin
                    take = 1'b1;
                    if (first_q) begin
                        // Very first frame after reset: nothing was displayed yet,
                        // so there is no slot to release.
                        first_d = 1'b0;
                        slot_d  = '0;
                        base_d  = START_A;
                    end else begin
                        strobe = 1'b1;
                        if (slot_q == SLOT_LAST) begin
                            slot_d = '0;
                            base_d = START_A;
                        end else begin
                            slot_d = slot_q + 1'b1;
                            base_d = base_q + BPF_A;
                        end
                    end
                    addr_d  = base_d;
                    line_d  = '0;
                    word_d  = '0;
                    sof_d   = 1'b1;
                    state_d = S_AR;
                end
`ifdef FRAME_RD_CTRL_REPEAT_EN
                else if (!first_q) begin
                    // Writer is behind: show the current slot again.
                    addr_d  = base_q;
                    line_d  = '0;
                    word_d  = '0;
                    sof_d   = 1'b1;
                    state_d = S_AR;
                end
`endif
            end
            S_AR: begin
                if (mem_arready_i) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (r_hs) begin
                    // Lines are contiguous, so a running byte address equals
                    // slot base + line*BPL + word*8.
                    addr_d = addr_q + WORD_BYTES;
                    word_d = word_q + 1'b1;
                    sof_d  = 1'b0;
                    if (mem_rlast_i) begin
                        if (word_d == WPL_C) begin
                            word_d  = '0;
                            line_d  = line_q + 1'b1;
                            state_d = (line_d == LINES_C) ? S_FRAME_SEL : S_AR;
                        end else begin
                            state_d = S_AR;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Increment and take in the same cycle cancel out.
        if (wr_done_stb_i && !take) begin
            if (avail_q != AVAIL_MAX) begin
                avail_d = avail_q + 1'b1;
            end
        end else if (take && !wr_done_stb_i) begin
            avail_d = avail_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            avail_q <= '0;
            first_q <= 1'b1;
            slot_q  <= '0;
            base_q  <= START_A;
            addr_q  <= START_A;
            word_q  <= '0;
            line_q  <= '0;
            sof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            avail_q <= avail_d;
            first_q <= first_d;
            slot_q  <= slot_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            line_q  <= line_d;
            sof_q   <= sof_d;
        end
    end

    // Burst length: whatever is left of the line, capped at BURST_LEN.
    always_comb begin
        remain = WPL - 32'(word_q);
        burst  = (remain < BURST_LEN) ? remain : BURST_LEN;
    end

    assign rd_done_stb_o = strobe;

    assign mem_awvalid_o = 1'b0;
    assign mem_wvalid_o  = 1'b0;
    assign mem_bready_o  = 1'b1;

    assign mem_arvalid_o = (state_q == S_AR);
    assign mem_araddr_o  = addr_q;
    assign mem_arlen_o   = 8'(burst - 32'd1);
    assign mem_arsize_o  = 3'd3;
    assign mem_arburst_o = 2'b01;
    assign mem_arid_o    = 4'd0;

    // R data passes straight through; rready mirrors tready so a stalled
    // consumer holds the memory beat in place.
    assign mem_rready_o   = in_r && video_tready_i;
    assign video_tvalid_o = in_r && mem_rvalid_i;
    assign video_tdata_o  = in_r ? mem_rdata_i : 64'd0;
    assign video_tuser_o  = in_r && sof_q;
    assign video_tlast_o  = in_r && (word_q == LAST_WORD);
    assign video_tkeep_o  = in_r ? ((word_q == LAST_WORD) ? LAST_KEEP : 8'hFF) : 8'h00;
    assign video_tstrb_o  = video_tkeep_o;
    assign video_tid_o    = 4'd0;
    assign video_tdest_o  = 4'd0;

endmodule

// File: tb/tb_frame_rd_ctrl.sv
module tb_frame_rd_ctrl;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct packed {
        logic [63:0] data;
        logic        user;
        logic        last;
        logic [7:0]  keep;
    } w_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0, wr = 1'b0, rst14 = 1'b0, wr14 = 1'b0;
    bit   rand_tr = 1'b0;

    // main DUT (FRAME_RES_X = 16)
    logic        d_rd_done, d_awvalid, d_wvalid, d_bready;
    logic [3:0]  d_arid;
    logic [31:0] d_araddr;
    logic [7:0]  d_arlen;
    logic [2:0]  d_arsize;
    logic [1:0]  d_arburst;
    logic        d_arvalid, d_arready;
    logic [63:0] d_rdata;
    logic        d_rlast, d_rvalid, d_rready;
    logic [63:0] d_tdata;
    logic [7:0]  d_tkeep, d_tstrb;
    logic        d_tuser, d_tlast, d_tvalid, d_tready;
    logic [3:0]  d_tid, d_tdest;

    // second DUT (FRAME_RES_X = 14)
    logic        x_rd_done, x_awvalid, x_wvalid, x_bready;
    logic [3:0]  x_arid;
    logic [31:0] x_araddr;
    logic [7:0]  x_arlen;
    logic [2:0]  x_arsize;
    logic [1:0]  x_arburst;
    logic        x_arvalid, x_arready;
    logic [63:0] x_rdata;
    logic        x_rlast, x_rvalid, x_rready;
    logic [63:0] x_tdata;
    logic [7:0]  x_tkeep, x_tstrb;
    logic        x_tuser, x_tlast, x_tvalid;
    logic [3:0]  x_tid, x_tdest;

    frame_rd_ctrl #(
        .START_ADDR(64'h1000), .FRAMES_AMOUNT(3), .FRAME_RES_Y(4),
        .FRAME_RES_X(16), .ADDR_WIDTH(32), .BURST_LEN(2)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .wr_done_stb_i(wr), .rd_done_stb_o(d_rd_done),
        .mem_awvalid_o(d_awvalid), .mem_wvalid_o(d_wvalid), .mem_bready_o(d_bready),
        .mem_arid_o(d_arid), .mem_araddr_o(d_araddr), .mem_arlen_o(d_arlen),
        .mem_arsize_o(d_arsize), .mem_arburst_o(d_arburst),
        .mem_arvalid_o(d_arvalid), .mem_arready_i(d_arready),
        .mem_rdata_i(d_rdata), .mem_rlast_i(d_rlast), .mem_rvalid_i(d_rvalid),
        .mem_rready_o(d_rready),
        .video_tdata_o(d_tdata), .video_tkeep_o(d_tkeep), .video_tstrb_o(d_tstrb),
        .video_tuser_o(d_tuser), .video_tlast_o(d_tlast), .video_tid_o(d_tid),
        .video_tdest_o(d_tdest), .video_tvalid_o(d_tvalid), .video_tready_i(d_tready)
    );

    frame_rd_ctrl #(
        .START_ADDR(64'h1000), .FRAMES_AMOUNT(3), .FRAME_RES_Y(4),
        .FRAME_RES_X(14), .ADDR_WIDTH(32), .BURST_LEN(2)
    ) u_dut14 (
        .clk_i(clk), .rst_i(rst14), .wr_done_stb_i(wr14), .rd_done_stb_o(x_rd_done),
        .mem_awvalid_o(x_awvalid), .mem_wvalid_o(x_wvalid), .mem_bready_o(x_bready),
        .mem_arid_o(x_arid), .mem_araddr_o(x_araddr), .mem_arlen_o(x_arlen),
        .mem_arsize_o(x_arsize), .mem_arburst_o(x_arburst),
        .mem_arvalid_o(x_arvalid), .mem_arready_i(x_arready),
        .mem_rdata_i(x_rdata), .mem_rlast_i(x_rlast), .mem_rvalid_i(x_rvalid),
        .mem_rready_o(x_rready),
        .video_tdata_o(x_tdata), .video_tkeep_o(x_tkeep), .video_tstrb_o(x_tstrb),
        .video_tuser_o(x_tuser), .video_tlast_o(x_tlast), .video_tid_o(x_tid),
        .video_tdest_o(x_tdest), .video_tvalid_o(x_tvalid), .video_tready_i(1'b1)
    );

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {~a, a};
    endfunction

    // memory slave for the main DUT
    initial begin : rsp_main
        int          beats;
        logic [31:0] cur, a_cap;
        logic [7:0]  l_cap;
        logic        ar_hs, r_hs;
        beats = 0; cur = 0;
        d_arready = 1'b1; d_rvalid = 1'b0; d_rlast = 1'b0; d_rdata = 64'd0;
        forever begin
            @(negedge clk);
            ar_hs = d_arvalid && d_arready;
            r_hs  = d_rvalid && d_rready;
            a_cap = d_araddr;
            l_cap = d_arlen;
            @(posedge clk);
            #1;
            if (rst) begin
                beats = 0;
            end else begin
                if (r_hs) begin cur = cur + 32'd8; beats = beats - 1; end
                if (ar_hs) begin cur = a_cap; beats = int'(l_cap) + 1; end
            end
            d_arready = (beats == 0);
            d_rvalid  = (beats > 0);
            d_rlast   = (beats == 1);
            d_rdata   = mem_word(cur);
        end
    end

    // memory slave for the X=14 DUT
    initial begin : rsp_x14
        int          beats;
        logic [31:0] cur, a_cap;
        logic [7:0]  l_cap;
        logic        ar_hs, r_hs;
        beats = 0; cur = 0;
        x_arready = 1'b1; x_rvalid = 1'b0; x_rlast = 1'b0; x_rdata = 64'd0;
        forever begin
            @(negedge clk);
            ar_hs = x_arvalid && x_arready;
            r_hs  = x_rvalid && x_rready;
            a_cap = x_araddr;
            l_cap = x_arlen;
            @(posedge clk);
            #1;
            if (rst14) begin
                beats = 0;
            end else begin
                if (r_hs) begin cur = cur + 32'd8; beats = beats - 1; end
                if (ar_hs) begin cur = a_cap; beats = int'(l_cap) + 1; end
            end
            x_arready = (beats == 0);
            x_rvalid  = (beats > 0);
            x_rlast   = (beats == 1);
            x_rdata   = mem_word(cur);
        end
    end

    initial begin : tready_drv
        d_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            d_tready = rand_tr ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    int  checks = 0;
    int  errors = 0;
    int  rd_seen = 0;
    int  k14 = 0;
    ar_t exp_ar[$];
    w_t  exp_w[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic push_words(input logic [31:0] base);
        w_t w;
        for (int i = 0; i < 16; i++) begin
            w.data = mem_word(base + 32'(i * 8));
            w.user = (i == 0);
            w.last = (i % 4 == 3);
            w.keep = 8'hFF;
            exp_w.push_back(w);
        end
    endtask

    task automatic push_frame(input logic [31:0] base);
        ar_t a;
        for (int l = 0; l < 4; l++) begin
            for (int b = 0; b < 2; b++) begin
                a.addr = base + 32'(l * 32 + b * 16);
                a.len  = 8'd1;
                exp_ar.push_back(a);
            end
        end
        push_words(base);
    endtask

    task automatic pulse_wr();
        @(negedge clk); wr = 1'b1;
        @(negedge clk); wr = 1'b0;
    endtask

    task automatic wait_q(input int lvl, input int budget, input string nm);
        int n;
        n = 0;
        while (exp_w.size() > lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_w.size() > lvl) begin
            errors++;
            $display("FAIL %s: timeout with %0d words outstanding, required at most %0d",
                     nm, exp_w.size(), lvl);
        end
    endtask

    task automatic monitor();
        ar_t a;
        w_t  w;
        forever begin
            @(negedge clk);
            if (d_rd_done) rd_seen++;
            if (d_arvalid && d_arready) begin
                if (exp_ar.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ar_unexpected: got araddr %0h, required no request", d_araddr);
                end else begin
                    a = exp_ar.pop_front();
                    chk("araddr", 64'(d_araddr), 64'(a.addr));
                    chk("arlen", 64'(d_arlen), 64'(a.len));
                end
            end
            if (d_tvalid) chk("rready_eq_tready", 64'(d_rready), 64'(d_tready));
            if (d_tvalid && d_tready) begin
                if (exp_w.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL word_unexpected: got tdata %0h, required no word", d_tdata);
                end else begin
                    w = exp_w.pop_front();
                    chk("tdata", d_tdata, w.data);
                    chk("tuser", 64'(d_tuser), 64'(w.user));
                    chk("tlast", 64'(d_tlast), 64'(w.last));
                    chk("tkeep", 64'(d_tkeep), 64'(w.keep));
                end
            end
            if (x_tvalid) begin
                chk("x14_tkeep", 64'(x_tkeep), (k14 % 4 == 3) ? 64'h0F : 64'hFF);
                chk("x14_tlast", 64'(x_tlast), (k14 % 4 == 3) ? 64'd1 : 64'd0);
                chk("x14_tuser", 64'(x_tuser), (k14 % 16 == 0) ? 64'd1 : 64'd0);
                k14++;
            end
        end
    endtask

    initial begin : main
        ar_t fr0_ar[8];
        int  n;
        int  exp_rd;

        // first-frame AR vectors: address, arlen
        fr0_ar[0] = '{addr: 32'h1000, len: 8'd1};
        fr0_ar[1] = '{addr: 32'h1010, len: 8'd1};
        fr0_ar[2] = '{addr: 32'h1020, len: 8'd1};
        fr0_ar[3] = '{addr: 32'h1030, len: 8'd1};
        fr0_ar[4] = '{addr: 32'h1040, len: 8'd1};
        fr0_ar[5] = '{addr: 32'h1050, len: 8'd1};
        fr0_ar[6] = '{addr: 32'h1060, len: 8'd1};
        fr0_ar[7] = '{addr: 32'h1070, len: 8'd1};

        fork
            monitor();
        join_none

        #1;
        rst = 1'b1; rst14 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_arvalid", 64'(d_arvalid), 64'd0);
        chk("rst_rready", 64'(d_rready), 64'd0);
        chk("rst_tvalid", 64'(d_tvalid), 64'd0);
        chk("rst_tdata", d_tdata, 64'd0);
        chk("rst_tuser", 64'(d_tuser), 64'd0);
        chk("rst_tlast", 64'(d_tlast), 64'd0);
        chk("rst_tkeep", 64'(d_tkeep), 64'd0);
        chk("rst_rd_done", 64'(d_rd_done), 64'd0);
        chk("tie_awvalid", 64'(d_awvalid), 64'd0);
        chk("tie_wvalid", 64'(d_wvalid), 64'd0);
        chk("tie_bready", 64'(d_bready), 64'd1);
        rst = 1'b0; rst14 = 1'b0;
        repeat (6) @(negedge clk);

        // first frame from the vector table
        for (int i = 0; i < 8; i++) exp_ar.push_back(fr0_ar[i]);
        push_words(32'h1000);
`ifdef FRAME_RD_CTRL_REPEAT_EN
        push_frame(32'h1000);
`endif
        pulse_wr();
        @(negedge clk); wr14 = 1'b1;
        @(negedge clk); wr14 = 1'b0;

`ifdef FRAME_RD_CTRL_REPEAT_EN
        wait_q(12, 400, "repeat_frame");
        chk("repeat_no_strobe", 64'(rd_seen), 64'd0);
`else
        wait_q(0, 400, "frame0");
        repeat (20) @(negedge clk);
        chk("idle_no_strobe", 64'(rd_seen), 64'd0);
`endif
        push_frame(32'h1080);
        pulse_wr();
        wait_q(14, 400, "frame_1080_start");
        chk("strobe_1080", 64'(rd_seen), 64'd1);

        // four more pulses: avail saturates at three frames
        rand_tr = 1'b1;
        push_frame(32'h1100);
        push_frame(32'h1000);
        push_frame(32'h1080);
`ifdef FRAME_RD_CTRL_REPEAT_EN
        push_frame(32'h1080);
`endif
        repeat (4) pulse_wr();
`ifdef FRAME_RD_CTRL_REPEAT_EN
        wait_q(16, 2000, "ring_frames");
        rand_tr = 1'b0;
        exp_rd = 4;
`else
        wait_q(0, 2000, "ring_frames");
        rand_tr = 1'b0;
        repeat (20) @(negedge clk);
        chk("ring_strobes", 64'(rd_seen), 64'd4);
        push_frame(32'h1100);
        pulse_wr();
        exp_rd = 5;
`endif

        // reset while a word of line 2 is on the bus
        n = 0;
        while (!(exp_w.size() <= 7 && d_tvalid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(exp_w.size() <= 7 && d_tvalid)) begin
            errors++;
            $display("FAIL line2_wait: timeout with %0d words outstanding, required at most 7",
                     exp_w.size());
        end
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_tvalid", 64'(d_tvalid), 64'd0);
        chk("midrst_arvalid", 64'(d_arvalid), 64'd0);
        chk("midrst_rready", 64'(d_rready), 64'd0);
        chk("midrst_tdata", d_tdata, 64'd0);
        chk("midrst_tuser", 64'(d_tuser), 64'd0);
        chk("strobes_before_rst", 64'(rd_seen), 64'(exp_rd));
        exp_w.delete();
        exp_ar.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        push_frame(32'h1000);
        pulse_wr();
        wait_q(0, 400, "restart_frame");
        chk("restart_no_strobe", 64'(rd_seen), 64'(exp_rd));
`ifndef FRAME_RD_CTRL_REPEAT_EN
        repeat (20) @(negedge clk);
`endif
        chk("x14_words_seen", 64'(k14 >= 16), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
